// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM-stage
// CPU port and the debug/loader port, with a fixed number of memory wait states.
module dmem_arbiter #(
   parameter int WORD_LEN    = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_rd_en,
   input  logic                cpu_wr_en,
   input  logic [WORD_LEN-1:0] cpu_addr,
   input  logic [WORD_LEN-1:0] cpu_wdata,
   output logic [WORD_LEN-1:0] cpu_rdata,
   output logic                cpu_stall,
   input  logic                dbg_req,
   input  logic                dbg_we,
   input  logic [WORD_LEN-1:0] dbg_addr,
   input  logic [WORD_LEN-1:0] dbg_wdata,
   output logic [WORD_LEN-1:0] dbg_rdata,
   output logic                dbg_ack,
   output logic                mem_rd_en,
   output logic                mem_wr_en,
   output logic [WORD_LEN-1:0] mem_addr,
   output logic [WORD_LEN-1:0] mem_wdata,
   input  logic [WORD_LEN-1:0] mem_rdata
);

   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   owner_t              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_LEN-1:0] addr_q, addr_d;
   logic [WORD_LEN-1:0] wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                cpu_done_q, cpu_done_d;
   logic                dbg_done_q, dbg_done_d;
   logic [WORD_LEN-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [WORD_LEN-1:0] dbg_rdata_q, dbg_rdata_d;

   logic cpu_req;
   logic cpu_elig;
   logic dbg_elig;
   logic busy;

   assign cpu_req  = cpu_rd_en | cpu_wr_en;
   // A port whose done pulse is high must not be re-granted on a still-held request.
   assign cpu_elig = cpu_req & ~cpu_done_q;
   assign dbg_elig = dbg_req & ~dbg_done_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      cpu_done_d   = 1'b0;
      dbg_done_d   = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (cpu_elig && (!dbg_elig || last_grant_q == OWN_DBG)) begin
               state_d      = BUSY;
               owner_d      = OWN_CPU;
               last_grant_d = OWN_CPU;
               cnt_d        = CNT_W'(WAIT_STATES);
               addr_d       = cpu_addr;
               wdata_d      = cpu_wdata;
               we_d         = cpu_wr_en;
            end else if (dbg_elig) begin
               state_d      = BUSY;
               owner_d      = OWN_DBG;
               last_grant_d = OWN_DBG;
               cnt_d        = CNT_W'(WAIT_STATES);
               addr_d       = dbg_addr;
               wdata_d      = dbg_wdata;
               we_d         = dbg_we;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = IDLE;
               if (owner_q == OWN_CPU) begin
                  cpu_done_d = 1'b1;
                  if (!we_q) cpu_rdata_d = mem_rdata;
               end else begin
                  dbg_done_d = 1'b1;
                  if (!we_q) dbg_rdata_d = mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_CPU;
         last_grant_q <= OWN_DBG;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         cpu_done_q   <= 1'b0;
         dbg_done_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all update together at the edge.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         cpu_done_q   <= cpu_done_d;
         dbg_done_q   <= dbg_done_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   // Gating with rst keeps a final-cycle write from escaping in the reset cycle.
   assign busy      = (state_q == BUSY) & ~rst;
   assign mem_rd_en = busy & ~we_q;
   assign mem_wr_en = busy & we_q & (cnt_q == '0);
   assign mem_addr  = busy ? addr_q  : '0;
   assign mem_wdata = busy ? wdata_q : '0;

   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign dbg_ack   = dbg_done_q;
   assign cpu_stall = cpu_elig;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with two wait states, one with none,
// each backed by a small word-addressed memory model.
module tb_dmem_arbiter;

   logic clk, rst;

   logic        cpu_rd_en, cpu_wr_en, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_ack;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        z_cpu_rd_en, z_cpu_wr_en, z_cpu_stall;
   logic [31:0] z_cpu_addr, z_cpu_wdata, z_cpu_rdata;
   logic        z_dbg_req, z_dbg_we, z_dbg_ack;
   logic [31:0] z_dbg_addr, z_dbg_wdata, z_dbg_rdata;
   logic        z_mem_rd_en, z_mem_wr_en;
   logic [31:0] z_mem_addr, z_mem_wdata, z_mem_rdata;

   logic [31:0] mem2 [1024];
   logic [31:0] mem0 [1024];
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_val;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.WORD_LEN(32), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst),
      .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.WORD_LEN(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst),
      .cpu_rd_en(z_cpu_rd_en), .cpu_wr_en(z_cpu_wr_en), .cpu_addr(z_cpu_addr),
      .cpu_wdata(z_cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
      .dbg_req(z_dbg_req), .dbg_we(z_dbg_we), .dbg_addr(z_dbg_addr),
      .dbg_wdata(z_dbg_wdata), .dbg_rdata(z_dbg_rdata), .dbg_ack(z_dbg_ack),
      .mem_rd_en(z_mem_rd_en), .mem_wr_en(z_mem_wr_en), .mem_addr(z_mem_addr),
      .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata   = mem2[mem_addr[11:2]];
   assign z_mem_rdata = mem0[z_mem_addr[11:2]];

   always @(posedge clk) begin
      if (pl_en) begin
         mem2[pl_idx] <= pl_val;
         mem0[pl_idx] <= pl_val;
      end else begin
         if (mem_wr_en)   mem2[mem_addr[11:2]]   <= mem_wdata;
         if (z_mem_wr_en) mem0[z_mem_addr[11:2]] <= z_mem_wdata;
      end
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      pl_en  = 1'b1;
      pl_idx = idx;
      pl_val = val;
      tick();
      pl_en  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      preload(10'h100, 32'hDEADBEEF);
      preload(10'h101, 32'h0);
      preload(10'h103, 32'h0);
      preload(10'h104, 32'h0BADF00D);
      cpu_rd_en   = 1'b1;
      z_cpu_rd_en = 1'b1;
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b1)   begin failures++; $display("FAIL rst_stall_follows_req got=%0b exp=1", cpu_stall); end
      checks++; if (z_cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_stall_ws0 got=%0b exp=1", z_cpu_stall); end
      checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%0b%0b exp=00", mem_rd_en, mem_wr_en); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      checks++; if (dbg_ack !== 1'b0)     begin failures++; $display("FAIL rst_dbg_ack got=%0b exp=0", dbg_ack); end
      checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", cpu_rdata, dbg_rdata); end
      tick();
      cpu_rd_en   = 1'b0;
      z_cpu_rd_en = 1'b0;
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0)   begin failures++; $display("FAIL rst_stall_no_req got=%0b exp=0", cpu_stall); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_cpu_load();
      logic [4:0] e_rd = 5'b01110;
      logic [4:0] e_st = 5'b01111;
      for (int c = 0; c <= 4; c++) begin
         tick();
         if (c == 0) begin cpu_rd_en = 1'b1; cpu_addr = 32'h400; end
         @(negedge clk);
         checks++; if (mem_rd_en !== e_rd[c]) begin failures++; $display("FAIL load_rd_en c=%0d got=%0b exp=%0b", c, mem_rd_en, e_rd[c]); end
         checks++; if (cpu_stall !== e_st[c]) begin failures++; $display("FAIL load_stall c=%0d got=%0b exp=%0b", c, cpu_stall, e_st[c]); end
         checks++; if (mem_wr_en !== 1'b0)    begin failures++; $display("FAIL load_wr_en c=%0d got=%0b exp=0", c, mem_wr_en); end
         if (c >= 1 && c <= 3) begin
            checks++; if (mem_addr !== 32'h400) begin failures++; $display("FAIL load_addr c=%0d got=%h exp=400", c, mem_addr); end
         end
         if (c < 4) begin
            checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL load_rdata_early c=%0d got=%h exp=0", c, cpu_rdata); end
         end else begin
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", cpu_rdata); end
         end
      end
      tick();
      cpu_rd_en = 1'b0;
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL load_idle got=%0b%0b exp=00", cpu_stall, mem_rd_en); end
   endtask

   task automatic test_cpu_store();
      logic [4:0] e_wr = 5'b01000;
      logic [4:0] e_st = 5'b01111;
      for (int c = 0; c <= 4; c++) begin
         tick();
         if (c == 0) begin cpu_wr_en = 1'b1; cpu_addr = 32'h404; cpu_wdata = 32'h12345678; end
         @(negedge clk);
         checks++; if (mem_wr_en !== e_wr[c]) begin failures++; $display("FAIL store_wr_en c=%0d got=%0b exp=%0b", c, mem_wr_en, e_wr[c]); end
         checks++; if (mem_rd_en !== 1'b0)    begin failures++; $display("FAIL store_rd_en c=%0d got=%0b exp=0", c, mem_rd_en); end
         checks++; if (cpu_stall !== e_st[c]) begin failures++; $display("FAIL store_stall c=%0d got=%0b exp=%0b", c, cpu_stall, e_st[c]); end
         if (c == 3) begin
            checks++; if (mem_addr !== 32'h404 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL store_bus got=%h/%h exp=404/12345678", mem_addr, mem_wdata); end
         end
      end
      tick();
      cpu_wr_en = 1'b0;
      cpu_wdata = 32'h0;
      @(negedge clk);
      checks++; if (mem2[10'h101] !== 32'h12345678) begin failures++; $display("FAIL store_mem got=%h exp=12345678", mem2[10'h101]); end
   endtask

   task automatic test_tie();
      logic [14:0] e_rd  = 15'b001110011101110;
      logic [14:0] e_ack = 15'b000000100000000;
      logic [14:0] e_st  = 15'b000001000001111;
      logic [31:0] e_addr;
      tick();
      rst = 1'b1;
      for (int c = 0; c <= 14; c++) begin
         tick();
         if (c == 0) begin
            rst = 1'b0;
            cpu_rd_en = 1'b1; cpu_addr = 32'h400;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h404;
         end
         if (c == 5)  cpu_rd_en = 1'b0;
         if (c == 9)  cpu_rd_en = 1'b1;
         if (c == 10) begin cpu_rd_en = 1'b0; dbg_req = 1'b0; end
         @(negedge clk);
         e_addr = !e_rd[c] ? 32'h0 : (c >= 5 && c <= 7) ? 32'h404 : 32'h400;
         checks++; if (mem_rd_en !== e_rd[c])  begin failures++; $display("FAIL tie_rd_en c=%0d got=%0b exp=%0b", c, mem_rd_en, e_rd[c]); end
         checks++; if (mem_addr !== e_addr)    begin failures++; $display("FAIL tie_addr c=%0d got=%h exp=%h", c, mem_addr, e_addr); end
         checks++; if (dbg_ack !== e_ack[c])   begin failures++; $display("FAIL tie_ack c=%0d got=%0b exp=%0b", c, dbg_ack, e_ack[c]); end
         checks++; if (cpu_stall !== e_st[c])  begin failures++; $display("FAIL tie_stall c=%0d got=%0b exp=%0b", c, cpu_stall, e_st[c]); end
         if (c == 4) begin
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL tie_cpu_rdata got=%h exp=deadbeef", cpu_rdata); end
         end
         if (c == 8) begin
            checks++; if (dbg_rdata !== 32'h12345678) begin failures++; $display("FAIL tie_dbg_rdata got=%h exp=12345678", dbg_rdata); end
         end
      end
   endtask

   task automatic test_dbg_rw();
      logic [5:0]  e_ack = 6'b010000;
      logic [5:0]  e_wr, e_rd;
      logic [31:0] e_prev;
      for (int a = 0; a < 2; a++) begin
         e_wr   = (a == 0) ? 6'b001000 : 6'b000000;
         e_rd   = (a == 0) ? 6'b000000 : 6'b001110;
         e_prev = 32'h12345678;
         for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 0) begin
               dbg_req = 1'b1; dbg_we = (a == 0); dbg_addr = 32'h408; dbg_wdata = 32'hA5A5A5A5;
            end
            if (c == 5) dbg_req = 1'b0;
            @(negedge clk);
            checks++; if (dbg_ack !== e_ack[c])  begin failures++; $display("FAIL dbg_ack a=%0d c=%0d got=%0b exp=%0b", a, c, dbg_ack, e_ack[c]); end
            checks++; if (mem_wr_en !== e_wr[c]) begin failures++; $display("FAIL dbg_wr_en a=%0d c=%0d got=%0b exp=%0b", a, c, mem_wr_en, e_wr[c]); end
            checks++; if (mem_rd_en !== e_rd[c]) begin failures++; $display("FAIL dbg_rd_en a=%0d c=%0d got=%0b exp=%0b", a, c, mem_rd_en, e_rd[c]); end
            checks++; if (cpu_stall !== 1'b0)    begin failures++; $display("FAIL dbg_cpu_stall a=%0d c=%0d got=%0b exp=0", a, c, cpu_stall); end
            if (a == 0 && c == 3) begin
               checks++; if (mem_addr !== 32'h408 || mem_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL dbg_wr_bus got=%h/%h exp=408/a5a5a5a5", mem_addr, mem_wdata); end
            end
            if (a == 1 && c == 3) begin
               checks++; if (dbg_rdata !== e_prev) begin failures++; $display("FAIL dbg_rdata_held got=%h exp=%h", dbg_rdata, e_prev); end
            end
            if (a == 1 && c == 4) begin
               checks++; if (dbg_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL dbg_rdata got=%h exp=a5a5a5a5", dbg_rdata); end
            end
         end
      end
   endtask

   task automatic test_reset_mid_store();
      for (int c = 0; c <= 5; c++) begin
         tick();
         if (c == 0) begin cpu_wr_en = 1'b1; cpu_addr = 32'h40C; cpu_wdata = 32'hCAFEF00D; end
         if (c == 2) rst = 1'b1;
         if (c == 3) begin rst = 1'b0; cpu_wr_en = 1'b0; end
         @(negedge clk);
         checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en c=%0d got=%0b exp=0", c, mem_wr_en); end
         if (c == 1) begin
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rstmid_rdata_before got=%h exp=deadbeef", cpu_rdata); end
         end
         if (c == 2) begin
            checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rstmid_stall got=%0b exp=1", cpu_stall); end
         end
         if (c >= 3) begin
            checks++; if (mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_idle c=%0d got=%0b/%h exp=0/0", c, mem_rd_en, mem_addr); end
            checks++; if (dbg_ack !== 1'b0)  begin failures++; $display("FAIL rstmid_ack c=%0d got=%0b exp=0", c, dbg_ack); end
            checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata c=%0d got=%h/%h exp=0/0", c, cpu_rdata, dbg_rdata); end
         end
      end
      checks++; if (mem2[10'h103] !== 32'h0) begin failures++; $display("FAIL rstmid_mem got=%h exp=0", mem2[10'h103]); end
   endtask

   task automatic test_zero_wait();
      logic [6:0] e_rd = 7'b0010010;
      logic [6:0] e_st = 7'b0011011;
      for (int c = 0; c <= 6; c++) begin
         tick();
         if (c == 0) begin z_cpu_rd_en = 1'b1; z_cpu_addr = 32'h410; end
         if (c == 6) z_cpu_rd_en = 1'b0;
         @(negedge clk);
         checks++; if (z_mem_rd_en !== e_rd[c]) begin failures++; $display("FAIL ws0_rd_en c=%0d got=%0b exp=%0b", c, z_mem_rd_en, e_rd[c]); end
         checks++; if (z_cpu_stall !== e_st[c]) begin failures++; $display("FAIL ws0_stall c=%0d got=%0b exp=%0b", c, z_cpu_stall, e_st[c]); end
         checks++; if (z_mem_wr_en !== 1'b0)    begin failures++; $display("FAIL ws0_wr_en c=%0d got=%0b exp=0", c, z_mem_wr_en); end
         if (c == 1) begin
            checks++; if (z_mem_addr !== 32'h410) begin failures++; $display("FAIL ws0_addr got=%h exp=410", z_mem_addr); end
            checks++; if (z_cpu_rdata !== 32'h0)  begin failures++; $display("FAIL ws0_rdata_early got=%h exp=0", z_cpu_rdata); end
         end
         if (c == 2) begin
            checks++; if (z_cpu_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL ws0_rdata got=%h exp=0badf00d", z_cpu_rdata); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      z_cpu_rd_en = 1'b0; z_cpu_wr_en = 1'b0; z_cpu_addr = '0; z_cpu_wdata = '0;
      z_dbg_req = 1'b0; z_dbg_we = 1'b0; z_dbg_addr = '0; z_dbg_wdata = '0;

      test_reset();
      test_cpu_load();
      test_cpu_store();
      test_tie();
      test_dbg_rw();
      test_reset_mid_store();
      test_zero_wait();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Models a memory with a fixed number of wait states.
- Arbitrates round-robin, sequences each access through a small FSM, and stalls the pipeline until the CPU access completes.
- Sits between the MEM stage/hazard unit and the data memory.

Parameters:
- WORD_LEN, 32, data/address width.
- WAIT_STATES, 2, extra memory cycles per access (>=0); counter width clog2(WAIT_STATES+1), min 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- cpu_rd_en  input  1  MEM-stage load request.
- cpu_wr_en  input  1  MEM-stage store request.
- cpu_addr  input  WORD_LEN  CPU byte address.
- cpu_wdata  input  WORD_LEN  CPU store data.
- cpu_rdata  output  WORD_LEN  CPU load data.
- cpu_stall  output  1  freeze pipeline.
- dbg_req  input  1  debug request.
- dbg_we  input  1  1 = write, 0 = read.
- dbg_addr  input  WORD_LEN  debug address.
- dbg_wdata  input  WORD_LEN  debug write data.
- dbg_rdata  output  WORD_LEN  debug read data.
- dbg_ack  output  1  one-cycle completion pulse.
- mem_rd_en  output  1  memory read strobe.
- mem_wr_en  output  1  memory write strobe.
- mem_addr  output  WORD_LEN  memory address.
- mem_wdata  output  WORD_LEN  memory write data.
- mem_rdata  input  WORD_LEN  memory read data.

Behaviour:
- Request definitions:
  - cpu_req = cpu_rd_en | cpu_wr_en. If both are high, the access is a write.
  - dbg request = dbg_req.
- FSM has two states: IDLE and BUSY.
- Registers: owner (CPU/DBG), last_grant, cnt, latched addr/wdata/we, cpu_done, dbg_done.
- IDLE:
  - Eligible requests are cpu_req & ~cpu_done and dbg_req & ~dbg_done. A port's request is ignored in the cycle its own done pulse is high, so a request still held is not re-granted.
  - With one eligible requester, grant it.
  - With both eligible, grant the one that is not last_grant.
  - On grant: latch addr/wdata/we, set owner, set last_grant = owner, cnt = WAIT_STATES, go to BUSY.
  - No grant: stay in IDLE.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_rd_en = ~we for every BUSY cycle.
  - mem_wr_en = we only in the final BUSY cycle (cnt==0), so exactly one write occurs per access.
  - While cnt != 0: decrement cnt.
  - When cnt == 0: capture mem_rdata into cpu_rdata or dbg_rdata (reads only; the owner's rdata register is otherwise held), pulse the owner's done register for the next cycle, go to IDLE.
- Outside BUSY: mem_rd_en = mem_wr_en = 0; mem_addr and mem_wdata = 0.
- Outputs:
  - dbg_ack = dbg_done.
  - cpu_stall = cpu_req & ~cpu_done (combinational).
- Latency: a request arriving in IDLE at cycle 0 occupies BUSY for cycles 1..WAIT_STATES+1. Done is high in cycle WAIT_STATES+2. The CPU is stalled for WAIT_STATES+2 cycles.
- Data validity: rdata is valid in the done cycle and held until the owner's next read capture.
- A request arriving while BUSY waits; a CPU request waiting this way keeps cpu_stall high.
- dbg_req dropped mid-access: the access completes and dbg_ack still pulses. dbg_req must be held until ack.
- cpu_req dropped mid-access (flush): the access completes. cpu_stall follows cpu_req.
- Back-to-back:
  - After a CPU done, a pending DBG request is granted in the done cycle. The next CPU request then waits for the full DBG access.
  - With only CPU requesting, the next CPU access may be granted in the cycle after its done.
- Reset mid-operation: next state IDLE, cnt = 0, done regs = 0, rdata regs = 0, last_grant = DBG (CPU wins the first tie). No write strobe is issued in the reset cycle or after it.
- Reset values: cpu_rdata = 0, dbg_rdata = 0, dbg_ack = 0, mem_* strobes/address/data = 0. cpu_stall equals cpu_req while reset is asserted.

Test Plan:
1. CPU load, WAIT_STATES=2: cpu_rd_en=1, addr 0x400, memory holds 0xDEADBEEF -> mem_rd_en high in cycles 1-3, cpu_stall high in cycles 0-3, low in cycle 4, cpu_rdata=0xDEADBEEF in cycle 4.
2. CPU store: cpu_wr_en=1, addr 0x404, wdata 0x12345678 -> mem_wr_en high in exactly one cycle (cycle 3) with mem_addr=0x404 and mem_wdata=0x12345678; mem_rd_en stays 0.
3. Simultaneous request after reset: cpu_rd_en and dbg_req rise together -> CPU granted first; DBG granted in the CPU done cycle; dbg_ack in cycle 8; next simultaneous tie goes to CPU again.
4. DBG write 0xA5A5A5A5 to 0x408, then DBG read of 0x408 -> dbg_ack pulses once per access; dbg_rdata=0xA5A5A5A5.
5. Reset asserted in BUSY cycle 2 of a store -> no mem_wr_en pulse, FSM in IDLE, dbg_ack=0, cpu_rdata=0 after the reset edge.
6. WAIT_STATES=0: CPU load -> one BUSY cycle, stall for 2 cycles, done in cycle 2; a held CPU request is not re-granted in its done cycle.
